median_scan_ctrl: RTL and testbench

//  Frame scan sequencer at the head of the median-filter pipeline.
//  - On Start: walks the source image in a column-sliding raster and issues single-pixel reads.
//  - Assembles each 3x3 window from the returned data.
//  - Feeds the window, centre row/col, MemWrite and Enable into the F pipeline stage.
//  - Interior pixels only; steady-state throughput is 1 window per 3 cycles.

---
 rtl/median_pkg.sv | 18 +
 rtl/median_window_reg.sv | 46 ++++
 rtl/median_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_median_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types for the median-filter scan front end.
// Scan FSM states plus pixel and 3x3 window types.
package median_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } state_e;

  typedef logic [DW_DEF-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;

endpackage

// File: rtl/median_window_reg.sv
// 3x3 window shift register fed one column at a time.
// win_o already includes the column completing on this cycle.
module median_window_reg
  import median_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_i,
  input  logic                    row_i,
  input  logic                    shift_i,
  input  logic [DW-1:0]           data_i,
  output logic [2:0][2:0][DW-1:0] win_o
);

  logic [1:0][DW-1:0]       col_q;
  logic [2:0][2:0][DW-1:0]  win_q;
  logic [2:0][2:0][DW-1:0]  win_d;

  always_comb begin
    win_d = win_q;
    if (shift_i) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = col_q[0];
      win_d[1][2] = col_q[1];
      win_d[2][2] = data_i;
    end
  end

  assign win_o = win_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      win_q <= '0;
    end else begin
      if (wr_i) col_q[row_i] <= data_i;
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/median_scan_ctrl.sv
// Frame scan sequencer: issues column-sliding raster reads
// and emits one 3x3 window per completed interior column.
module median_scan_ctrl
  import median_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    WrEn,
  input  logic                    Hold,
  output logic                    Busy,
  output logic                    Done,
  output logic                    RD_en,
  output logic [AW-1:0]           RD_row,
  output logic [AW-1:0]           RD_col,
  input  logic [DW-1:0]           RD_data,
  output logic                    F_Enable,
  output logic                    F_MemWrite,
  output logic [AW-1:0]           F_row,
  output logic [AW-1:0]           F_col,
  output logic [2:0][2:0][DW-1:0] F_DIN
);

  localparam logic [AW-1:0] RC_LAST = AW'(ROWS - 2);
  localparam logic [AW-1:0] C_LAST  = AW'(COLS - 1);

  state_e        state_q;
  logic [AW-1:0] rc_q, c_q;
  logic [1:0]    ph_q;
  logic [AW-1:0] rd_rc_q;
  logic [1:0]    rd_ph_q;
  logic          pend_q;
  logic [AW-1:0] pend_rc_q, pend_c_q;
  logic [1:0]    pend_ph_q;
  logic          wr_q;

  logic          idle, issue, last;
  logic [AW-1:0] rc_c, c_c;
  logic [1:0]    ph_c;
  logic          col_wr, col_shift;
  logic [2:0][2:0][DW-1:0] win;

  // In IDLE the first read uses the frame-start counter values.
  assign idle  = (state_q == IDLE);
  assign rc_c  = idle ? AW'(1) : rc_q;
  assign c_c   = idle ? '0 : c_q;
  assign ph_c  = idle ? 2'd0 : ph_q;
  assign issue = !Hold && ((idle && Start) || state_q == READ);
  assign last  = (rc_c == RC_LAST) && (c_c == C_LAST)
              && (ph_c == 2'd2);

  assign col_wr    = pend_q && (pend_ph_q != 2'd2);
  assign col_shift = pend_q && (pend_ph_q == 2'd2);

  median_window_reg #(.DW(DW)) u_win (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .wr_i    (col_wr),
    .row_i   (pend_ph_q[0]),
    .shift_i (col_shift),
    .data_i  (RD_data),
    .win_o   (win)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      c_q        <= '0;
      ph_q       <= '0;
      rd_rc_q    <= '0;
      rd_ph_q    <= '0;
      pend_q     <= 1'b0;
      pend_rc_q  <= '0;
      pend_c_q   <= '0;
      pend_ph_q  <= '0;
      wr_q       <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      RD_en      <= 1'b0;
      RD_row     <= '0;
      RD_col     <= '0;
      F_Enable   <= 1'b0;
      F_MemWrite <= 1'b0;
      F_row      <= '0;
      F_col      <= '0;
      F_DIN      <= '0;
    end else begin
      Done      <= 1'b0;
      F_Enable  <= 1'b0;
      RD_en     <= issue;
      pend_q    <= RD_en;
      pend_rc_q <= rd_rc_q;
      pend_c_q  <= RD_col;
      pend_ph_q <= rd_ph_q;

      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q <= READ;
            Busy    <= 1'b1;
            wr_q    <= WrEn;
            rc_q    <= AW'(1);
            c_q     <= '0;
            ph_q    <= '0;
          end
        end
        READ: begin
          if (issue && last) state_q <= FLUSH;
        end
        FLUSH: begin
          if (F_Enable) begin
            state_q <= DONE;
            Done    <= 1'b1;
            Busy    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (issue) begin
        RD_row  <= rc_c + AW'(ph_c) - AW'(1);
        RD_col  <= c_c;
        rd_rc_q <= rc_c;
        rd_ph_q <= ph_c;
        if (ph_c != 2'd2) begin
          ph_q <= ph_c + 2'd1;
          c_q  <= c_c;
          rc_q <= rc_c;
        end else if (!last) begin
          ph_q <= 2'd0;
          if (c_c == C_LAST) begin
            c_q  <= '0;
            rc_q <= rc_c + AW'(1);
          end else begin
            c_q  <= c_c + AW'(1);
            rc_q <= rc_c;
          end
        end
      end

      // A column bottom from c >= 2 closes a full interior window.
      if (col_shift && pend_c_q >= AW'(2)) begin
        F_Enable   <= 1'b1;
        F_MemWrite <= wr_q;
        F_row      <= pend_rc_q;
        F_col      <= pend_c_q - AW'(1);
        F_DIN      <= win;
      end
    end
  end

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed bench for median_scan_ctrl on a 5x5 frame
// with pixel (r,c) = 16*r + c.
module tb_median_scan_ctrl;
  import median_pkg::*;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int N    = 3 * COLS * (ROWS - 2);

  typedef struct {
    int rc;
    int c;
    int rd;
  } wvec_t;

  typedef struct {
    int n;
    int row;
    int col;
  } rd_rec_t;

  typedef struct {
    int          n;
    int          row;
    int          col;
    logic [71:0] din;
    logic        mw;
  } fw_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic wren = 1'b0;
  logic hold = 1'b0;
  logic busy, done, rd_en, f_en, f_mw;
  logic [AW-1:0] rd_row, rd_col, f_row, f_col;
  logic [DW-1:0] rd_data = '0;
  logic [2:0][2:0][DW-1:0] f_din;
  logic [100:0] all_o;

  int tests = 0;
  int fails = 0;
  wvec_t tbl [9];

  median_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .DW(DW)
  ) dut (
    .Clock      (clk),
    .Reset_n    (rst_n),
    .Start      (start),
    .WrEn       (wren),
    .Hold       (hold),
    .Busy       (busy),
    .Done       (done),
    .RD_en      (rd_en),
    .RD_row     (rd_row),
    .RD_col     (rd_col),
    .RD_data    (rd_data),
    .F_Enable   (f_en),
    .F_MemWrite (f_mw),
    .F_row      (f_row),
    .F_col      (f_col),
    .F_DIN      (f_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rd_data <= 8'(16 * int'(rd_row) + int'(rd_col));

  assign all_o = {busy, done, rd_en, rd_row, rd_col,
                  f_en, f_mw, f_row, f_col, f_din};

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rd_cyc(input int k, input int pre,
                                input int hs, input int hl);
    int e;
    e = k + pre;
    if (hl > 0 && e > hs) e += hl;
    return e;
  endfunction

  task automatic run_frame(input string tag, input logic wr,
                           input int pre, input int hs, input int hl,
                           input bit restart, input bit tog);
    rd_rec_t rq[$];
    fw_rec_t wq[$];
    int done_n, bfirst, blast, bcnt, idx, rc, cc, row, e;
    bit seen;
    window_t w;
    done_n = -1; bfirst = -1; blast = -1; bcnt = 0; seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (rd_en) rq.push_back('{n, int'(rd_row), int'(rd_col)});
      if (f_en)
        wq.push_back('{n, int'(f_row), int'(f_col), f_din, f_mw});
      if (busy) begin
        if (bfirst < 0) bfirst = n;
        blast = n;
        bcnt++;
      end
      if (done) begin
        done_n = n;
        seen = 1;
      end
      start = (n == 0) || (restart && n == 30);
      wren  = (tog && n > 0) ? 1'(n % 2) : wr;
      hold  = (n < pre) || (n >= hs && n < hs + hl);
    end
    start = 1'b0;
    hold  = 1'b0;
    chk({tag, " done_seen"}, 128'(seen), 128'(1));
    e = rd_cyc(N, pre, hs, hl) + 3;
    chk({tag, " done_cycle"}, 128'(done_n), 128'(e));
    chk({tag, " busy_first"}, 128'(bfirst), 128'(1));
    chk({tag, " busy_last"}, 128'(blast), 128'(e - 1));
    chk({tag, " busy_count"}, 128'(bcnt), 128'(e - 1));
    chk({tag, " read_count"}, 128'(rq.size()), 128'(N));
    for (int k = 1; k <= N && k <= rq.size(); k++) begin
      idx = k - 1;
      rc  = 1 + idx / 15;
      cc  = (idx % 15) / 3;
      row = rc - 1 + idx % 3;
      chk($sformatf("%s read%0d n/row/col", tag, k),
          {32'(rq[idx].n), 32'(rq[idx].row), 32'(rq[idx].col)},
          {32'(rd_cyc(k, pre, hs, hl)), 32'(row), 32'(cc)});
    end
    chk({tag, " window_count"}, 128'(wq.size()), 128'(9));
    for (int i = 0; i < 9 && i < wq.size(); i++) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++)
          w[a][b] = 8'(16 * (tbl[i].rc - 1 + a) + tbl[i].c - 1 + b);
      chk($sformatf("%s win%0d n/row/col/mw", tag, i),
          {32'(wq[i].n), 32'(wq[i].row), 32'(wq[i].col), 31'd0, wq[i].mw},
          {32'(rd_cyc(tbl[i].rd, pre, hs, hl) + 2), 32'(tbl[i].rc),
           32'(tbl[i].c), 31'd0, wr});
      chk($sformatf("%s win%0d din", tag, i), 128'(wq[i].din), 128'(w));
    end
    @(negedge clk);
    chk({tag, " after_done"}, {125'd0, done, busy, rd_en}, 128'(0));
  endtask

  initial begin
    tbl[0] = '{1, 1, 9};  tbl[1] = '{1, 2, 12}; tbl[2] = '{1, 3, 15};
    tbl[3] = '{2, 1, 24}; tbl[4] = '{2, 2, 27}; tbl[5] = '{2, 3, 30};
    tbl[6] = '{3, 1, 39}; tbl[7] = '{3, 2, 42}; tbl[8] = '{3, 3, 45};

    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom);
      wren  = 1'($urandom);
      hold  = 1'($urandom);
      #1 chk("reset outputs", 128'(all_o), 128'(0));
    end
    @(negedge clk);
    start = 1'b0; wren = 1'b0; hold = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle busy/rd_en", {126'd0, busy, rd_en}, 128'(0));
    end

    run_frame("plain", 1'b1, 0, 0, 0, 1'b0, 1'b0);
    run_frame("midhold", 1'b1, 0, 19, 4, 1'b0, 1'b0);
    run_frame("restart", 1'b1, 0, 0, 0, 1'b1, 1'b0);
    run_frame("prehold", 1'b1, 3, 0, 0, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1; wren = 1'b1; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort busy before reset", 128'(busy), 128'(1));
    #1 rst_n = 1'b0;
    #1 chk("abort async outputs", 128'(all_o), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("post_abort", 1'b1, 0, 0, 0, 1'b0, 1'b0);

    run_frame("wren_off", 1'b0, 0, 0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
